// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: optional functional capture, then CHAIN_LEN shift edges
// that load a new word into the chain while unloading the old contents.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 op,
   input  logic [CHAIN_LEN-1:0] load_data,
   input  logic                 scan_out,
   output logic                 scan_in,
   output logic                 scan_en,
   output logic                 capture,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] cap_data
);

   localparam int CNT_W = $clog2(CHAIN_LEN) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      CAPT  = 4'b0010,
      SHIFT = 4'b0100,
      DONE  = 4'b1000
   } state_e;

   state_e               state_q, state_d;
   logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CHAIN_LEN-1:0] cap_q, cap_d;
   logic [CHAIN_LEN-1:0] shifted;

   assign shifted = {scan_out, shreg_q[CHAIN_LEN-1:1]};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = op ? CAPT : SHIFT;
         CAPT:    state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      scan_en = 1'b0;
      capture = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      scan_in = 1'b0;
      case (state_q)
         IDLE:  busy = 1'b0;
         CAPT:  capture = 1'b1;
         SHIFT: begin
            scan_en = 1'b1;
            scan_in = shreg_q[0];
         end
         DONE:  done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Shift register doubles as the load source and the unload sink.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d = load_data;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) cap_d = shifted;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         cap_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
      end
   end

   assign cap_data = cap_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-cell behavioural DFF chain and an
// operation-level model of expected timing, capture value and final chain contents.
module tb_scan_chain_ctrl;

   localparam int N = 8;

   logic         CLK, RST, start, op, scan_out;
   logic [N-1:0] load_data, cap_data;
   logic         scan_in, scan_en, capture, busy, done;

   logic [N-1:0] chain, func_d, preset_val, exp_chain;
   logic         preset_en;
   int           n_pass, n_total, n_fail;

   scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
      .CLK(CLK), .RST(RST), .start(start), .op(op), .load_data(load_data),
      .scan_out(scan_out), .scan_in(scan_in), .scan_en(scan_en),
      .capture(capture), .busy(busy), .done(done), .cap_data(cap_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Chain of scan-muxed DFFs: cell i is chain[i], cell 0 drives scan_out.
   always @(posedge CLK) begin
      if (preset_en)    chain <= preset_val;
      else if (scan_en) chain <= {scan_in, chain[N-1:1]};
      else if (capture) chain <= func_d;
   end
   assign scan_out = chain[0];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic preset(input logic [N-1:0] v);
      start      = 1'b0;
      preset_val = v;
      preset_en  = 1'b1;
      tick();
      preset_en  = 1'b0;
      exp_chain  = v;
   endtask

   // Entered in an IDLE cycle; returns in the IDLE cycle after DONE.
   task automatic run_op(input logic o, input logic [N-1:0] ld, input logic hold);
      logic [N-1:0] exp_cap;
      int           last;
      exp_cap   = o ? func_d : exp_chain;
      last      = o ? N + 2 : N + 1;
      start     = 1'b1;
      op        = o;
      load_data = ld;
      tick();
      for (int k = 1; k <= last; k++) begin
         logic exp_se;
         int   sh;
         exp_se = o ? (k >= 2 && k <= N + 1) : (k <= N);
         sh     = o ? k - 2 : k - 1;
         chk1("scan_en", scan_en, exp_se);
         chk1("capture", capture, o && k == 1);
         chk1("busy", busy, 1'b1);
         chk1("done", done, k == last);
         chk1("scan_in", scan_in, exp_se ? ld[sh] : 1'b0);
         chk1("se_cap_excl", scan_en & capture, 1'b0);
         if (k == last) chk8("cap_data", cap_data, exp_cap);
         start     = hold ? 1'b1 : 1'($urandom % 2);
         op        = 1'($urandom % 2);
         load_data = N'($urandom);
         tick();
      end
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_done", done, 1'b0);
      chk1("idle_se", scan_en, 1'b0);
      chk1("idle_sin", scan_in, 1'b0);
      chk8("chain", chain, ld);
      chk8("cap_hold", cap_data, exp_cap);
      exp_chain = ld;
      start     = hold;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_se"}, scan_en, 1'b0);
      chk1({tag, "_cap"}, capture, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_done"}, done, 1'b0);
      chk1({tag, "_sin"}, scan_in, 1'b0);
      chk8({tag, "_capdata"}, cap_data, '0);
   endtask

   initial begin
      n_pass = 0; n_total = 0; n_fail = 0;
      RST = 1'b1; start = 1'b0; op = 1'b0; load_data = '0;
      preset_en = 1'b0; preset_val = '0; func_d = '0; exp_chain = '0;
      tick();
      tick();
      chk_all_zero("reset");
      RST = 1'b0;
      tick();

      // Reset while shifting with cnt=3
      preset(8'h11);
      start = 1'b1; op = 1'b0; load_data = 8'hC3;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk1("midshift_se", scan_en, 1'b1);
      #2 RST = 1'b1;
      #1 chk_all_zero("async_rst");
      tick();
      RST = 1'b0;
      tick();
      chk_all_zero("post_rst");
      preset(8'h96);
      run_op(1'b0, 8'h4E, 1'b0);

      // Shift-only and capture+shift directed cases
      preset(8'h3C);
      run_op(1'b0, 8'hA5, 1'b0);
      preset(8'h00);
      func_d = 8'h5A;
      run_op(1'b1, 8'hFF, 1'b0);

      // Back-to-back with start held high
      preset(8'h77);
      run_op(1'b0, 8'h12, 1'b1);
      run_op(1'b0, 8'h34, 1'b1);
      run_op(1'b0, 8'h56, 1'b0);

      // Walking one
      run_op(1'b0, 8'h01, 1'b0);
      run_op(1'b0, 8'h80, 1'b0);

      for (int i = 0; i < 24; i++) begin
         logic h;
         func_d = N'($urandom);
         h      = (i % 6 == 5) ? 1'b0 : 1'($urandom % 2);
         run_op(1'($urandom % 2), N'($urandom), h);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
